// File: rtl/ext_domain_powergate_ctrl.sv
// Power-gating sequencer for one switchable domain: isolation, switch cell,
// domain reset and acknowledge handshake with a sticky timeout flag.
//
// state          | meaning
// ST_ON          | domain powered, isolation off, reset released
// ST_ISO_ASSERT  | isolation clamped, waiting ISO_DELAY before switch-off
// ST_SW_OFF_WAIT | switch off, reset asserted, waiting for ack_s low
// ST_OFF         | domain unpowered, isolated, in reset
// ST_SW_ON_WAIT  | switch on, waiting for ack_s high
// ST_RST_RELEASE | powered, holding domain reset for RST_DELAY
// ST_ISO_RELEASE | reset released, holding isolation for ISO_DELAY
module ext_domain_powergate_ctrl #(
  parameter int ISO_DELAY   = 4,
  parameter int RST_DELAY   = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_off_i,
  input  logic req_on_i,
  output logic switch_o,
  input  logic switch_ack_i,
  output logic iso_o,
  output logic domain_rst_o,
  output logic busy_o,
  output logic powered_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int MAX_A   = (ISO_DELAY > RST_DELAY) ? ISO_DELAY : RST_DELAY;
  localparam int MAX_DLY = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_DLY + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_DELAY - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_ON,
    ST_ISO_ASSERT,
    ST_SW_OFF_WAIT,
    ST_OFF,
    ST_SW_ON_WAIT,
    ST_RST_RELEASE,
    ST_ISO_RELEASE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], switch_ack_i};
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Each transition clears cnt and sets that state's outputs, so they appear
  // in the first cycle of the new state. Terminal compare uses DELAY-1 since
  // cnt is 0 in the entry cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_ON;
      cnt          <= '0;
      switch_o     <= 1'b1;
      iso_o        <= 1'b0;
      domain_rst_o <= 1'b0;
      busy_o       <= 1'b0;
      powered_o    <= 1'b1;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      case (state)
        ST_ON: begin
          if (req_off_i) begin
            state     <= ST_ISO_ASSERT;
            cnt       <= '0;
            iso_o     <= 1'b1;
            busy_o    <= 1'b1;
            powered_o <= 1'b0;
            timeout_o <= 1'b0;
          end
        end
        ST_ISO_ASSERT: begin
          if (cnt == ISO_LAST) begin
            state        <= ST_SW_OFF_WAIT;
            cnt          <= '0;
            switch_o     <= 1'b0;
            domain_rst_o <= 1'b1;
          end
        end
        ST_SW_OFF_WAIT: begin
          if (!ack_s) begin
            state  <= ST_OFF;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (cnt == ACK_LAST) begin
            timeout_o <= 1'b1;
          end
        end
        ST_OFF: begin
          if (req_on_i) begin
            state     <= ST_SW_ON_WAIT;
            cnt       <= '0;
            switch_o  <= 1'b1;
            busy_o    <= 1'b1;
            timeout_o <= 1'b0;
          end
        end
        ST_SW_ON_WAIT: begin
          if (ack_s) begin
            state <= ST_RST_RELEASE;
            cnt   <= '0;
          end else if (cnt == ACK_LAST) begin
            timeout_o <= 1'b1;
          end
        end
        ST_RST_RELEASE: begin
          if (cnt == RST_LAST) begin
            state        <= ST_ISO_RELEASE;
            cnt          <= '0;
            domain_rst_o <= 1'b0;
          end
        end
        ST_ISO_RELEASE: begin
          if (cnt == ISO_LAST) begin
            state     <= ST_ON;
            cnt       <= '0;
            iso_o     <= 1'b0;
            busy_o    <= 1'b0;
            powered_o <= 1'b1;
            done_o    <= 1'b1;
          end
        end
        default: begin
          state        <= ST_ON;
          cnt          <= '0;
          switch_o     <= 1'b1;
          iso_o        <= 1'b0;
          domain_rst_o <= 1'b0;
          busy_o       <= 1'b0;
          powered_o    <= 1'b1;
        end
      endcase
    end
  end

endmodule
